// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Integer execute unit: add/sub, RV32I-style R-type ALU ops and, when the
//   ALU_EXEC_MULDIV_EN macro is defined, multiply (1 cycle) and a restoring
//   divider (one quotient bit per cycle). Requests and responses use
//   valid/ready handshakes. Only one operation is in flight at a time.
//
//   Ports
//     clk       rising-edge clock
//     rst_n     asynchronous active-low reset
//     ALUop     op class: 00 add, 01 sub, 10 R-type decode, 11 reserved
//     funct7    R-type funct7 field
//     funct3    R-type funct3 field
//     op_a/op_b operands (rs1, rs2), XLEN bits
//     in_valid  request valid         in_ready  request ready (IDLE only)
//     out_valid response valid        out_ready response ready
//     result    registered result     illegal   registered illegal-decode flag
//
//   Build option: `define ALU_EXEC_MULDIV_EN enables the M-extension ops;
//   without it funct7 0000001 decodes as illegal and no DIV state exists.
module alu_exec_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      ALUop,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    if (!(XLEN == 8 || XLEN == 16 || XLEN == 32 || XLEN == 64))
        $error("alu_exec_unit: XLEN must be 8, 16, 32 or 64");
    if (CNT_W < $clog2(XLEN) + 1)
        $error("alu_exec_unit: CNT_W too narrow to hold XLEN");

`ifdef ALU_EXEC_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_RESP} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_RESP} state_t;
`endif

    state_t state_q, state_d;

    logic [XLEN-1:0] result_q;
    logic            illegal_q;
    logic [XLEN-1:0] alu_res;
    logic            alu_ill;
    logic            div_start;
    logic [SHW-1:0]  shamt;

`ifdef ALU_EXEC_MULDIV_EN
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   quo_q, rem_q, dvsr_q;
    logic              qneg_q, rneg_q, isrem_q;

    logic [2*XLEN-1:0] ext_a, ext_b, prod;
    logic              div_signed, a_neg, b_neg;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN:0]     rem_sh, diff;
    logic [XLEN-1:0]   rem_nx, quo_nx, q_fin, r_fin;

    // Multiplier operands are sign- or zero-extended to 2*XLEN so a single
    // truncated product yields the correct high half for all MULH variants.
    always_comb begin
        ext_a = (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10)
              ? {{XLEN{op_a[XLEN-1]}}, op_a} : {{XLEN{1'b0}}, op_a};
        ext_b = (funct3[1:0] == 2'b01)
              ? {{XLEN{op_b[XLEN-1]}}, op_b} : {{XLEN{1'b0}}, op_b};
        prod  = ext_a * ext_b;

        div_signed = ~funct3[0];
        a_neg      = div_signed & op_a[XLEN-1];
        b_neg      = div_signed & op_b[XLEN-1];
        abs_a      = a_neg ? -op_a : op_a;
        abs_b      = b_neg ? -op_b : op_b;
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder, keep the subtraction only if it did not go negative.
    always_comb begin
        rem_sh = {rem_q, quo_q[XLEN-1]};
        diff   = rem_sh - {1'b0, dvsr_q};
        if (!diff[XLEN]) begin
            rem_nx = diff[XLEN-1:0];
            quo_nx = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh[XLEN-1:0];
            quo_nx = {quo_q[XLEN-2:0], 1'b0};
        end
        q_fin = qneg_q ? -quo_nx : quo_nx;
        r_fin = rneg_q ? -rem_nx : rem_nx;
    end
`endif

    // Decode and single-cycle datapath, evaluated on the request inputs.
    always_comb begin
        alu_res   = '0;
        alu_ill   = 1'b0;
        div_start = 1'b0;
        shamt     = op_b[SHW-1:0];
        case (ALUop)
            2'b00: alu_res = op_a + op_b;
            2'b01: alu_res = op_a - op_b;
            2'b10: begin
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  alu_res = op_a + op_b;
                            3'b001:  alu_res = op_a << shamt;
                            3'b010:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
                            3'b011:  alu_res = XLEN'(op_a < op_b);
                            3'b100:  alu_res = op_a ^ op_b;
                            3'b101:  alu_res = op_a >> shamt;
                            3'b110:  alu_res = op_a | op_b;
                            default: alu_res = op_a & op_b;
                        endcase
                    end
                    7'b0100000: begin
                        case (funct3)
                            3'b000:  alu_res = op_a - op_b;
                            3'b101:  alu_res = $signed(op_a) >>> shamt;
                            default: alu_ill = 1'b1;
                        endcase
                    end
`ifdef ALU_EXEC_MULDIV_EN
                    7'b0000001: begin
                        if (!funct3[2]) begin
                            alu_res = (funct3[1:0] == 2'b00) ? prod[XLEN-1:0]
                                                             : prod[2*XLEN-1:XLEN];
                        end else if (op_b == '0) begin
                            alu_res = funct3[1] ? op_a : '1;
                        end else if (div_signed && op_a == SMIN && op_b == '1) begin
                            alu_res = funct3[1] ? '0 : op_a;
                        end else begin
                            div_start = 1'b1;
                        end
                    end
`endif
                    default: alu_ill = 1'b1;
                endcase
            end
            default: alu_ill = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
`ifdef ALU_EXEC_MULDIV_EN
                    state_d = div_start ? S_DIV : S_RESP;
`else
                    state_d = S_RESP;
`endif
                end
            end
`ifdef ALU_EXEC_MULDIV_EN
            S_DIV: if (cnt_q == CNT_W'(1)) state_d = S_RESP;
`endif
            default: if (out_ready) state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_RESP);
        result    = result_q;
        illegal   = illegal_q;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q  <= '0;
            illegal_q <= 1'b0;
`ifdef ALU_EXEC_MULDIV_EN
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            isrem_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        result_q  <= alu_res;
                        illegal_q <= alu_ill;
`ifdef ALU_EXEC_MULDIV_EN
                        if (div_start) begin
                            cnt_q   <= CNT_W'(XLEN);
                            quo_q   <= abs_a;
                            rem_q   <= '0;
                            dvsr_q  <= abs_b;
                            qneg_q  <= a_neg ^ b_neg;
                            rneg_q  <= a_neg;
                            isrem_q <= funct3[1];
                        end
`endif
                    end
                end
`ifdef ALU_EXEC_MULDIV_EN
                // The last iteration and the sign fix-up share one edge, so
                // the response appears right as the counter reaches zero.
                S_DIV: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    quo_q <= quo_nx;
                    rem_q <= rem_nx;
                    if (cnt_q == CNT_W'(1)) begin
                        result_q  <= isrem_q ? r_fin : q_fin;
                        illegal_q <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ALUop;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        in_valid, in_ready;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic        illegal;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ALUop     (ALUop),
        .funct7    (funct7),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    // Drives one request at a negedge once in_ready is seen; the expected
    // response is queued with the cycle number of the accepting cycle.
    task automatic issue(input string nm, input logic [1:0] op, input logic [6:0] f7,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic ill, input int lat);
        exp_t e;
        int   w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: in_ready timeout, got 0 expected 1", nm);
            return;
        end
        ALUop = op; funct7 = f7; funct3 = f3; op_a = a; op_b = b;
        in_valid = 1'b1;
        e.name = nm; e.res = res; e.ill = ill; e.lat = lat; e.acc = cyc;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain;
        int w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor / scoreboard checker
    logic prev_v = 1'b0;
    int   first_cyc = 0;
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && !prev_v) first_cyc = cyc;
        prev_v = out_valid;
        if (out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_response: out_valid 1 with nothing outstanding (result 0x%0h), expected out_valid 0", result);
            end else if (out_ready) begin
                e = sb.pop_front();
                check({e.name, ".result"},  64'(result), 64'(e.res));
                check({e.name, ".illegal"}, 64'(illegal), 64'(e.ill));
                check({e.name, ".latency"}, 64'(first_cyc - e.acc), 64'(e.lat));
            end else begin
                check({sb[0].name, ".hold_result"},  64'(result), 64'(sb[0].res));
                check({sb[0].name, ".hold_illegal"}, 64'(illegal), 64'(sb[0].ill));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic busy_ok;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ALUop = '0; funct7 = '0; funct3 = '0; op_a = '0; op_b = '0;
        #23;
        check("reset.in_ready",  64'(in_ready),  64'd1);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.result",    64'(result),    64'd0);
        check("reset.illegal",   64'(illegal),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue("add_wrap", 2'b00, 7'h00, 3'b000, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 1'b0, 1);
        issue("sub_wrap", 2'b01, 7'h00, 3'b000, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1);
        issue("r_add",    2'b10, 7'h00, 3'b000, 32'd5, 32'd7, 32'h0000_000C, 1'b0, 1);
        issue("r_sub",    2'b10, 7'h20, 3'b000, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
        issue("r_sra",    2'b10, 7'h20, 3'b101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1);
        issue("r_and",    2'b10, 7'h00, 3'b111, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1);
        issue("r_sll",    2'b10, 7'h00, 3'b001, 32'd1, 32'h0000_0025, 32'h0000_0020, 1'b0, 1);
        issue("r_slt",    2'b10, 7'h00, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
        issue("r_sltu",   2'b10, 7'h00, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
        issue("r_xor",    2'b10, 7'h00, 3'b100, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1'b0, 1);
        issue("r_srl",    2'b10, 7'h00, 3'b101, 32'h8000_0000, 32'd36, 32'h0800_0000, 1'b0, 1);
        issue("r_or",     2'b10, 7'h00, 3'b110, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0, 1'b0, 1);
        issue("ill_f3",   2'b10, 7'h20, 3'b001, 32'd1, 32'd1, 32'd0, 1'b1, 1);
        issue("ill_f7",   2'b10, 7'h7F, 3'b000, 32'd1, 32'd1, 32'd0, 1'b1, 1);
        issue("ill_op11", 2'b11, 7'h00, 3'b000, 32'd5, 32'd7, 32'd0, 1'b1, 1);
`ifdef ALU_EXEC_MULDIV_EN
        issue("mul",      2'b10, 7'h01, 3'b000, 32'd6, 32'd7, 32'd42, 1'b0, 1);
        issue("mul_lo",   2'b10, 7'h01, 3'b000, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1);
        issue("mulh",     2'b10, 7'h01, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1);
        issue("mulh_m1",  2'b10, 7'h01, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
        issue("mulhsu",   2'b10, 7'h01, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1);
        issue("mulhu",    2'b10, 7'h01, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1);

        issue("div_neg",  2'b10, 7'h01, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
        busy_ok = 1'b1;
        for (int i = 0; i < 31; i++) begin
            in_valid = 1'b1;   // must be ignored while dividing
            ALUop = 2'b00;
            if (in_ready) busy_ok = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("div_busy.in_ready_low", 64'(busy_ok), 64'd1);
        drain();
        issue("rem_neg",  2'b10, 7'h01, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
        issue("div_nb",   2'b10, 7'h01, 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33);
        issue("rem_nb",   2'b10, 7'h01, 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 33);
        issue("divu",     2'b10, 7'h01, 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        issue("remu",     2'b10, 7'h01, 3'b111, 32'd100, 32'd7, 32'd2, 1'b0, 33);
        issue("divu_z",   2'b10, 7'h01, 3'b101, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
        issue("remu_z",   2'b10, 7'h01, 3'b111, 32'd9, 32'd0, 32'd9, 1'b0, 1);
        issue("rem_ovf",  2'b10, 7'h01, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
        issue("div_ovf",  2'b10, 7'h01, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
`else
        issue("nomd_mul", 2'b10, 7'h01, 3'b000, 32'd6, 32'd7, 32'd0, 1'b1, 1);
        issue("nomd_div", 2'b10, 7'h01, 3'b100, 32'd9, 32'd2, 32'd0, 1'b1, 1);
`endif
        drain();

        // Backpressure: response held, new requests ignored.
        out_ready = 1'b0;
        issue("hold", 2'b10, 7'h00, 3'b100, 32'h1234_5678, 32'h0000_FFFF, 32'h1234_A987, 1'b0, 1);
        busy_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            ALUop = 2'b01; op_a = 32'd99; op_b = 32'd1;
            if (in_ready || !out_valid) busy_ok = 1'b0;
            @(negedge clk);
        end
        check("hold.in_ready_low_valid_high", 64'(busy_ok), 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (3) @(negedge clk);

        // Reset while a response is pending: it must disappear.
        out_ready = 1'b0;
        issue("rst_resp", 2'b00, 7'h00, 3'b000, 32'd1, 32'd1, 32'd2, 1'b0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_resp.out_valid", 64'(out_valid), 64'd0);
        check("rst_resp.in_ready",  64'(in_ready),  64'd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);

`ifdef ALU_EXEC_MULDIV_EN
        // Reset mid-divide: aborted, no response afterwards.
        issue("rst_div", 2'b10, 7'h01, 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_div.out_valid", 64'(out_valid), 64'd0);
        check("rst_div.in_ready",  64'(in_ready),  64'd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
`endif

        // Unit still works after the resets.
        issue("post_rst", 2'b10, 7'h00, 3'b000, 32'd5, 32'd7, 32'h0000_000C, 1'b0, 1);
        drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
